sdr_init_cmd_monitor: RTL and testbench

- Passive, synthesizable monitor on the SDRAM command pins of the SDRAM controller core.
- Decodes cs_n/ras_n/cas_n/we_n every sdram_clk edge and checks the power-up initialisation sequence: NOP wait, PRECHARGE, auto-refreshes, LOAD MODE REGISTER, then sdr_init_done.
- Captures the programmed mode register and counts refreshes after init.
- Drives the flags and counters the assertion interface and coverage collectors consume; it never drives the DUV.

---
 rtl/sdr_init_cmd_monitor_if.sv | 12 +
 rtl/sdr_init_cmd_monitor.sv | 117 +++++++++++
 tb/tb_sdr_init_cmd_monitor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_init_cmd_monitor_if.sv
// sdr_init_cmd_monitor_if: SDRAM command pins plus controller init-done flag, as seen by the monitor
interface sdr_init_cmd_monitor_if;
    logic        sdr_cke;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [12:0] sdr_addr;
    logic        sdr_init_done;
    modport master (output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_init_done);
    modport slave  (input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_init_done);
endinterface

// File: rtl/sdr_init_cmd_monitor.sv
// sdr_init_cmd_monitor: passive checker of the SDRAM power-up init sequence, mode capture and refresh count
module sdr_init_cmd_monitor #(
    parameter int PWRUP_NOPS   = 500,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 8,
    parameter int N_INIT_REF   = 2,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_resetn,
    sdr_init_cmd_monitor_if.slave  bus,
    output logic [2:0]             cmd_code,
    output logic                   init_ok,
    output logic                   init_err,
    output logic [2:0]             err_code,
    output logic [12:0]            mode_reg,
    output logic [2:0]             cas_latency,
    output logic [2:0]             burst_len,
    output logic [15:0]            ref_count
);
    localparam int GAP_MAX = T_RFC > T_RP ? (T_RFC > DONE_TIMEOUT ? T_RFC : DONE_TIMEOUT)
                                          : (T_RP > DONE_TIMEOUT ? T_RP : DONE_TIMEOUT);
    localparam int NW = $clog2(PWRUP_NOPS + 1);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int RW = $clog2(N_INIT_REF + 1);
    localparam logic [NW-1:0] NOPS_N = NW'(PWRUP_NOPS);
    localparam logic [GW-1:0] GAP_N  = GW'(GAP_MAX);
    localparam logic [GW-1:0] TRP_N  = GW'(T_RP);
    localparam logic [GW-1:0] TRFC_N = GW'(T_RFC);
    localparam logic [GW-1:0] TDONE_N = GW'(DONE_TIMEOUT);
    localparam logic [RW-1:0] NREF_N = RW'(N_INIT_REF);
    localparam logic [2:0] C_NOP = 3'b111, C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

    typedef enum logic [2:0] {PWRUP, PRE_WAIT, REF_WAIT, DONE_WAIT, INIT_OK, ERR} state_t;

    state_t          state, nxt;
    logic [NW-1:0]   nop_cnt;
    logic [GW-1:0]   since;
    logic [RW-1:0]   ref_init;
    logic [2:0]      cmd, seq_err, err;
    logic            nop, chk_done, chk_cke;

    assign cmd         = bus.sdr_cs_n ? C_NOP : {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
    assign nop         = cmd == C_NOP;
    assign cas_latency = mode_reg[6:4];
    assign burst_len   = mode_reg[2:0];

    // since = edges elapsed since the last timed command, counting the current edge
    always_comb begin
        seq_err = 3'd0;
        nxt     = state;
        case (state)
            PWRUP: if (!nop) begin
                seq_err = nop_cnt < NOPS_N ? 3'd1 : cmd != C_PRE ? 3'd2 : 3'd0;
                nxt     = PRE_WAIT;
            end
            PRE_WAIT: if (!nop) begin
                seq_err = since < TRP_N ? 3'd3 : cmd != C_REF ? 3'd2 : 3'd0;
                nxt     = REF_WAIT;
            end
            REF_WAIT: if (!nop) begin
                seq_err = since < TRFC_N ? 3'd4 : cmd == C_REF ? 3'd0 :
                          (cmd == C_MRS && ref_init >= NREF_N) ? 3'd0 : 3'd2;
                nxt     = cmd == C_MRS ? DONE_WAIT : REF_WAIT;
            end
            DONE_WAIT: begin
                seq_err = !nop ? 3'd2 : bus.sdr_init_done ? 3'd0 : since >= TDONE_N ? 3'd5 : 3'd0;
                nxt     = (nop && bus.sdr_init_done) ? INIT_OK : DONE_WAIT;
            end
            default: ;
        endcase
        chk_done = state == PWRUP || state == PRE_WAIT || state == REF_WAIT;
        chk_cke  = chk_done || state == DONE_WAIT;
        err      = seq_err != 3'd0 ? seq_err : (chk_done && bus.sdr_init_done) ? 3'd6 :
                   (chk_cke && !bus.sdr_cke) ? 3'd7 : 3'd0;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state     <= PWRUP;
            nop_cnt   <= '0;
            since     <= '0;
            ref_init  <= '0;
            cmd_code  <= C_NOP;
            init_ok   <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= 3'd0;
            mode_reg  <= '0;
            ref_count <= '0;
        end else begin
            cmd_code <= cmd;
            if (since != GAP_N)
                since <= since + 1'b1;
            if (err != 3'd0) begin
                state    <= ERR;
                init_err <= 1'b1;
                err_code <= err;
            end else begin
                state <= nxt;
                if (state == PWRUP && nop && nop_cnt != NOPS_N)
                    nop_cnt <= nop_cnt + 1'b1;
                if (!nop && state != INIT_OK)
                    since <= GW'(1);
                if (state == PRE_WAIT && !nop)
                    ref_init <= RW'(1);
                if (state == REF_WAIT && cmd == C_REF && ref_init != NREF_N)
                    ref_init <= ref_init + 1'b1;
                if (cmd == C_MRS && (state == REF_WAIT || state == INIT_OK))
                    mode_reg <= bus.sdr_addr;
                if (state == INIT_OK && cmd == C_REF && ref_count != 16'hFFFF)
                    ref_count <= ref_count + 1'b1;
                if (nxt == INIT_OK)
                    init_ok <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdr_init_cmd_monitor.sv
// tb_sdr_init_cmd_monitor: table-driven directed checks of the SDRAM init sequence monitor
module tb_sdr_init_cmd_monitor;
    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, REF = 3'b001, MRS = 3'b000, ACT = 3'b011;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    sdr_init_cmd_monitor_if bus();
    logic [2:0]  cmd_code, err_code, cas_latency, burst_len;
    logic        init_ok, init_err;
    logic [12:0] mode_reg;
    logic [15:0] ref_count;

    sdr_init_cmd_monitor dut (
        .sdram_clk(clk), .sdram_resetn(rst_n), .bus(bus.slave),
        .cmd_code(cmd_code), .init_ok(init_ok), .init_err(init_err), .err_code(err_code),
        .mode_reg(mode_reg), .cas_latency(cas_latency), .burst_len(burst_len), .ref_count(ref_count)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [12:0] addr;
        logic        done;
        logic        cke;
        int          reps;
        logic        ok;
        logic        err;
        logic [2:0]  code;
    } step_t;

    step_t steps[$];
    string scen;
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", scen, name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [12:0] a, input logic d, input logic k);
        bus.sdr_cs_n = (c == NOP) ? 1'($urandom_range(0, 1)) : 1'b0;
        {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = c;
        bus.sdr_addr      = a;
        bus.sdr_init_done = d;
        bus.sdr_cke       = k;
    endtask

    task automatic add(input logic [2:0] c, input int n, input logic ok, input logic er,
                       input logic [2:0] code, input logic d = 1'b0, input logic k = 1'b1,
                       input logic [12:0] a = 13'h0);
        steps.push_back('{cmd: c, addr: a, done: d, cke: k, reps: n, ok: ok, err: er, code: code});
    endtask

    task automatic add_prefix();
        add(NOP, 500, 0, 0, 0);
        add(PRE, 1, 0, 0, 0);
        add(NOP, 2, 0, 0, 0);
        add(REF, 1, 0, 0, 0);
    endtask

    task automatic add_to_mrs(input logic [12:0] a);
        add_prefix();
        add(NOP, 7, 0, 0, 0);
        add(REF, 1, 0, 0, 0);
        add(NOP, 7, 0, 0, 0);
        add(MRS, 1, 0, 0, 0, 1'b0, 1'b1, a);
    endtask

    task automatic run_steps();
        foreach (steps[i]) begin
            repeat (steps[i].reps) begin
                @(negedge clk);
                drive(steps[i].cmd, steps[i].addr, steps[i].done, steps[i].cke);
            end
            @(posedge clk);
            #1;
            check($sformatf("s%0d_init_ok", i), init_ok, steps[i].ok);
            check($sformatf("s%0d_init_err", i), init_err, steps[i].err);
            check($sformatf("s%0d_err_code", i), err_code, steps[i].code);
            check($sformatf("s%0d_cmd_code", i), cmd_code, steps[i].cmd);
        end
        steps.delete();
    endtask

    // Reset is asserted mid-cycle so the clearing is seen without any clock edge
    task automatic do_reset(input string name);
        scen = name;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        drive(NOP, 13'h0, 1'b0, 1'b1);
        #1;
        check("rst_cmd_code", cmd_code, 3'b111);
        check("rst_init_ok", init_ok, 1'b0);
        check("rst_init_err", init_err, 1'b0);
        check("rst_err_code", err_code, 3'd0);
        check("rst_mode_reg", mode_reg, 13'h0);
        check("rst_ref_count", ref_count, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(NOP, 13'h0, 1'b0, 1'b1);

        do_reset("legal");
        add_to_mrs(13'h0033);
        add(NOP, 3, 0, 0, 0);
        add(NOP, 1, 1, 0, 0, 1'b1);
        run_steps();
        check("mode_reg", mode_reg, 13'h0033);
        check("cas_latency", cas_latency, 3'd3);
        check("burst_len", burst_len, 3'd3);

        do_reset("early_pre");
        add(NOP, 499, 0, 0, 0);
        add(PRE, 1, 0, 1, 1);
        add(NOP, 3, 0, 1, 1);
        run_steps();

        do_reset("t_rfc");
        add_prefix();
        add(NOP, 4, 0, 0, 0);
        add(REF, 1, 0, 1, 4);
        add(REF, 1, 0, 1, 4);
        run_steps();

        do_reset("one_ref_mrs");
        add_prefix();
        add(NOP, 7, 0, 0, 0);
        add(MRS, 1, 0, 1, 2);
        run_steps();

        do_reset("timeout");
        add_to_mrs(13'h0032);
        add(NOP, 15, 0, 0, 0);
        add(NOP, 1, 0, 1, 5);
        run_steps();

        do_reset("done_at_limit");
        add_to_mrs(13'h0032);
        add(NOP, 15, 0, 0, 0);
        add(NOP, 1, 1, 0, 0, 1'b1);
        run_steps();

        do_reset("cke_low");
        add(NOP, 100, 0, 0, 0);
        add(NOP, 1, 0, 1, 7, 1'b0, 1'b0);
        add(NOP, 600, 0, 1, 7);
        add(PRE, 1, 0, 1, 7);
        run_steps();

        do_reset("t_rp");
        add(NOP, 500, 0, 0, 0);
        add(PRE, 1, 0, 0, 0);
        add(REF, 1, 0, 1, 3);
        run_steps();

        do_reset("priority");
        add(NOP, 10, 0, 0, 0);
        add(PRE, 1, 0, 1, 1, 1'b0, 1'b0);
        run_steps();

        do_reset("done_early");
        add(NOP, 10, 0, 0, 0);
        add(NOP, 1, 0, 1, 6, 1'b1);
        run_steps();

        do_reset("bad_order");
        add(NOP, 500, 0, 0, 0);
        add(ACT, 1, 0, 1, 2);
        run_steps();

        do_reset("ref_sat");
        add_to_mrs(13'h0033);
        add(NOP, 1, 1, 0, 0, 1'b1);
        run_steps();
        repeat (3) begin
            @(negedge clk);
            drive(REF, 13'h0, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1 check("ref_count_3", ref_count, 16'd3);
        repeat (69997) begin
            @(negedge clk);
            drive(REF, 13'h0, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1 check("ref_count_sat", ref_count, 16'hFFFF);
        @(negedge clk);
        drive(MRS, 13'h0023, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("remrs_mode_reg", mode_reg, 13'h0023);
        check("remrs_cas", cas_latency, 3'd2);
        check("remrs_burst", burst_len, 3'd3);
        check("remrs_init_ok", init_ok, 1'b1);
        check("remrs_ref_count", ref_count, 16'hFFFF);
        check("remrs_init_err", init_err, 1'b0);

        do_reset("mid_reset_pre");
        add_prefix();
        run_steps();
        do_reset("mid_reset");
        add_to_mrs(13'h0033);
        add(NOP, 2, 0, 0, 0);
        add(NOP, 1, 1, 0, 0, 1'b1);
        run_steps();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
